alu_issue_queue: RTL and testbench



---
 rtl/alu_issue_queue_pkg.sv | 11 +
 rtl/alu_issue_queue_if.sv | 31 +++
 rtl/alu_issue_queue_sync_fifo.sv | 59 +++++
 rtl/alu_issue_queue.sv | 104 ++++++++++
 tb/tb_alu_issue_queue.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_queue_pkg.sv
// rtl/alu_issue_queue_pkg.sv - op encoding and width shared by the issue queue and the ALU
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// rtl/alu_issue_queue_if.sv - request and result handshake bundle of the ALU issue queue
interface alu_issue_queue_if #(
  parameter int WIDTH = alu_pkg::ALU_W,
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  alu_op_t          in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  alu_op_t          out_op;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_op, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_op, out_tag
  );

endinterface

// File: rtl/alu_issue_queue_sync_fifo.sv
// rtl/alu_issue_queue_sync_fifo.sv - registered in-order FIFO, no write-to-read bypass
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_i) wr_d = ptr_next(wr_q);
    if (pop_i)  rd_d = ptr_next(rd_q);
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push_i) mem_q[wr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - issues ops into a fixed-latency ALU, tracks them in a shift pipe
// and captures results into a credit-protected result FIFO
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_W,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_queue_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PAY_W = WIDTH + 1 + TAG_W;

  logic                          issue, pop;
  logic [CNT_W-1:0]              outstanding_q, outstanding_d;
  logic [WIDTH-1:0]              alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [LATENCY:0]              v_q, v_d;
  logic [LATENCY:0]              op_q, op_d;
  logic [LATENCY:0][TAG_W-1:0]   tag_q, tag_d;

  logic                          fifo_push, fifo_full, fifo_empty;
  logic [PAY_W-1:0]              fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]              fifo_count;

  // Credits cover ops in the pipe as well as in the FIFO, so a capture never finds it full.
  assign bus.in_ready = (outstanding_q < CNT_W'(DEPTH));
  assign issue        = bus.in_valid & bus.in_ready;
  assign pop          = bus.out_valid & bus.out_ready;

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !pop)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!issue && pop) outstanding_d = outstanding_q - CNT_W'(1);
  end

  assign alu_a_d = issue ? bus.in_a : alu_a_q;
  assign alu_b_d = issue ? bus.in_b : alu_b_q;

  if (LATENCY == 0) begin : g_pipe_comb
    assign v_d   = issue;
    assign op_d  = issue ? logic'(bus.in_op) : op_q;
    assign tag_d = issue ? bus.in_tag : tag_q;
  end else begin : g_pipe_shift
    assign v_d   = {v_q[LATENCY-1:0], issue};
    assign op_d  = {op_q[LATENCY-1:0], issue ? logic'(bus.in_op) : op_q[0]};
    assign tag_d = {tag_q[LATENCY-1:0], issue ? bus.in_tag : tag_q[0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      v_q           <= '0;
      op_q          <= '0;
      tag_q         <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      v_q           <= v_d;
      op_q          <= op_d;
      tag_q         <= tag_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  // The ALU muxes its result with the live op, so drive it from the emerging stage.
  assign alu_op = op_q[LATENCY];

  assign fifo_push  = v_q[LATENCY];
  assign fifo_wdata = {alu_result, op_q[LATENCY], tag_q[LATENCY]};

  sync_fifo #(
    .WIDTH(PAY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (fifo_push),
    .wdata_i(fifo_wdata),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_rdata[PAY_W-1 -: WIDTH];
  assign bus.out_op    = alu_op_t'(fifo_rdata[TAG_W]);
  assign bus.out_tag   = fifo_rdata[TAG_W-1:0];

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue with a behavioural ALU
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int LAT = 1;

  typedef struct {
    logic [31:0] data;
    logic        op;
    logic [3:0]  tag;
    int          icyc;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_op;
  logic [31:0] alu_sum_q, alu_prod_q;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stalls = 0;
  bit   rnd_done = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_issue_queue_if #(.WIDTH(32), .TAG_W(4)) bus ();

  alu_issue_queue #(
    .WIDTH(32), .LATENCY(LAT), .TAG_W(4), .DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Small positive integers only, so float results are exact.
  function automatic logic [31:0] i2f(input int unsigned n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (n[i]) e = i;
    m = (n << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int unsigned f2i(input logic [31:0] f);
    int e;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    return {8'd0, 1'b1, f[22:0]} >> (23 - e);
  endfunction

  // One-stage ALU computing both results and muxing on the live op select.
  always @(posedge clk) begin
    alu_sum_q  <= i2f(f2i(alu_a) + f2i(alu_b));
    alu_prod_q <= i2f(f2i(alu_a) * f2i(alu_b));
  end
  assign alu_result = alu_op ? alu_prod_q : alu_sum_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp_data, input bit chk_lat);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = alu_op_t'(op);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    while (!bus.in_ready && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("issue_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back('{exp_data, op, tag, cyc, chk_lat});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic issue_rand(input bit chk_lat);
    int unsigned a, b;
    logic op;
    a  = $urandom_range(1, 16);
    b  = $urandom_range(1, 16);
    op = 1'($urandom_range(0, 1));
    issue(op, i2f(a), i2f(b), 4'($urandom_range(0, 15)), i2f(op ? a * b : a + b), chk_lat);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", bus.out_data, 32'hxxxx_xxxx);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", bus.out_data, mon_e.data);
        chk("out_op", 32'(bus.out_op), 32'(mon_e.op));
        chk("out_tag", 32'(bus.out_tag), 32'(mon_e.tag));
        if (mon_e.chk_lat) chk("latency", 32'(cyc - mon_e.icyc), 32'(LAT + 2));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(dut.u_fifo.push_i && dut.u_fifo.full_o)) else begin
        failures++;
        $display("FAIL fifo_overflow: push while full");
      end
      assert (!(dut.u_fifo.pop_i && dut.u_fifo.empty_o)) else begin
        failures++;
        $display("FAIL fifo_underflow: pop while empty");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_op", 32'(bus.out_op), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);

    bus.out_ready = 1'b1;
    issue(1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 1);
    drain("drain_add");
    issue(1'b1, 32'h4000_0000, 32'h4040_0000, 4'd9, 32'h40C0_0000, 1);
    drain("drain_mul");

    stalls = 0;
    for (int i = 0; i < 8; i++)
      issue(1'(i), 32'h4000_0000, 32'h4040_0000, 4'(i),
            (i % 2 == 1) ? 32'h40C0_0000 : 32'h40A0_0000, 1);
    chk("alt_stalls", 32'(stalls), 32'd0);
    drain("drain_alt");

    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      int unsigned a, b;
      logic op;
      @(negedge clk);
      a = $urandom_range(1, 16);
      b = $urandom_range(1, 16);
      op = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      bus.in_op    = alu_op_t'(op);
      bus.in_a     = i2f(a);
      bus.in_b     = i2f(b);
      bus.in_tag   = 4'(i);
      if (bus.in_ready) begin
        acc++;
        sb.push_back('{i2f(op ? a * b : a + b), op, 4'(i), cyc, 1'b0});
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b1;
    chk("bp_credit_hold", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("bp_credit_return", 32'(bus.in_ready), 32'd1);
    drain("drain_bp");

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue_rand(0);
    @(negedge clk);
    chk("rmf_out_valid_before", 32'(bus.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rmf_out_valid_async", 32'(bus.out_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      #3 chk("rmf_quiet", 32'(bus.out_valid), 32'd0);
      chk("rmf_in_ready", 32'(bus.in_ready), 32'd1);
    end
    issue(1'b0, i2f(5), i2f(7), 4'd5, 32'h4140_0000, 1);
    drain("drain_rmf");

    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_rand(0);
    repeat (4) @(negedge clk);
    chk("steady_full", 32'(bus.in_ready), 32'd0);
    stalls = 0;
    fork
      begin
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
      for (int i = 0; i < 20; i++) issue_rand(0);
    join
    chk("steady_stalls", 32'(stalls), 32'd1);
    drain("drain_steady");

    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) issue_rand(0);
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(negedge clk);
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    join
    bus.out_ready = 1'b1;
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
